instr_fetch_mem: RTL and testbench

- Instruction-memory responder on the far side of the program-counter interface in the single-cycle processor.
- Each cycle it takes the word address driven by the PC and returns the instruction word one cycle later.
- It also returns the decoded fields the PC consumes: the 28-bit jump field, the sign-extended immediate, and the conditional/unconditional branch flags.
- After reset, a boot-load state machine fills the memory through a valid/ready stream before fetch starts.

---
 rtl/instr_fetch_mem_if.sv | 22 ++
 rtl/instr_fetch_mem.sv | 126 ++++++++++++
 tb/tb_instr_fetch_mem.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_mem_if.sv
// Boot-load stream between the loader and the instruction memory.
// The loader drives valid/data/last and the memory returns ready.
interface instr_fetch_mem_if;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;

    modport master (
        output load_valid,
        output load_data,
        output load_last,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  load_last,
        output load_ready
    );
endinterface : instr_fetch_mem_if

// File: rtl/instr_fetch_mem.sv
// Instruction memory behind the PC. After reset it is boot-loaded over a
// valid/ready stream, then it returns one registered instruction word per
// cycle along with the decoded jump, immediate and branch fields.
module instr_fetch_mem #(
    parameter int DEPTH     = 256,
    parameter int AW        = 8,
    parameter bit BOOT_LOAD = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         direinstru,
    instr_fetch_mem_if.slave    load_if,
    output logic [31:0]         instruccion,
    output logic [27:0]         instru,
    output logic [31:0]         extSigno,
    output logic                SaltoCond,
    output logic                Saltoincond,
    output logic                fetch_valid,
    output logic                addr_err
);

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    typedef enum logic {
        ST_LOAD,
        ST_RUN
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_ptr;
    logic [31:0]   r_mem [DEPTH];
    logic [31:0]   r_instr;
    logic          r_fetch_valid;
    logic          r_addr_err;

    logic          w_load_ready;
    logic          w_wr_en;
    logic          w_run;
    logic          w_ptr_full;
    logic          w_in_range;

    assign w_ptr_full = (r_ptr == AW'(DEPTH - 1));
    assign w_in_range = (direinstru[31:AW] == '0);

    // State register. There is no path from RUN back to LOAD except reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= BOOT_LOAD ? ST_LOAD : ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    // NOTE: the default assignment at the top keeps this block free of
    // inferred latches on paths that do not change state.
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_LOAD && w_wr_en && (load_if.load_last || w_ptr_full)) begin
            w_state_nxt = ST_RUN;
        end
    end

    // State-decoded control outputs.
    always_comb begin
        w_load_ready = 1'b0;
        w_run        = 1'b0;
        unique case (r_state)
            ST_LOAD: w_load_ready = 1'b1;
            ST_RUN:  w_run        = 1'b1;
            default: ;
        endcase
        w_wr_en = w_load_ready && load_if.load_valid;
    end

    assign load_if.load_ready = w_load_ready;

    // The pointer parks on the last slot after a full load rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_wr_en && !w_ptr_full) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    // NOTE: the memory array has no reset; contents survive reset on purpose
    // and a reset-free array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_ptr] <= load_if.load_data;
        end
    end

    // Out-of-range fetches return a NOP; addresses never alias into the array.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr       <= '0;
            r_fetch_valid <= 1'b0;
            r_addr_err    <= 1'b0;
        end else if (w_run) begin
            r_fetch_valid <= 1'b1;
            if (w_in_range) begin
                r_instr    <= r_mem[direinstru[AW-1:0]];
                r_addr_err <= 1'b0;
            end else begin
                r_instr    <= '0;
                r_addr_err <= 1'b1;
            end
        end
    end

    // Decoded fields come only from the registered word so they stay coherent.
    assign instruccion = r_instr;
    assign fetch_valid = r_fetch_valid;
    assign addr_err    = r_addr_err;
    assign instru      = {2'b00, r_instr[25:0]};
    assign extSigno    = {{16{r_instr[15]}}, r_instr[15:0]};
    assign SaltoCond   = (r_instr[31:26] == OP_BEQ);
    assign Saltoincond = (r_instr[31:26] == OP_J);

endmodule : instr_fetch_mem

// File: tb/tb_instr_fetch_mem.sv
// Self-checking bench for instr_fetch_mem: directed boot/fetch steps plus
// randomized fetch traffic compared against an array model of the memory.
module tb_instr_fetch_mem;

    localparam int DEPTH = 256;

    logic        clk;
    logic        reset;
    logic [31:0] direinstru;
    logic [31:0] instruccion;
    logic [27:0] instru;
    logic [31:0] extSigno;
    logic        SaltoCond;
    logic        Saltoincond;
    logic        fetch_valid;
    logic        addr_err;

    instr_fetch_mem_if lif ();

    instr_fetch_mem #(
        .DEPTH     (DEPTH),
        .AW        (8),
        .BOOT_LOAD (1'b1)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .direinstru  (direinstru),
        .load_if     (lif),
        .instruccion (instruccion),
        .instru      (instru),
        .extSigno    (extSigno),
        .SaltoCond   (SaltoCond),
        .Saltoincond (Saltoincond),
        .fetch_valid (fetch_valid),
        .addr_err    (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int unsigned model_mem [DEPTH];
    int          model_ptr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] data, input logic last);
        lif.load_valid = 1'b1;
        lif.load_data  = data;
        lif.load_last  = last;
        tick();
        model_mem[model_ptr] = data;
        if (model_ptr < DEPTH - 1) model_ptr++;
        lif.load_valid = 1'b0;
        lif.load_last  = 1'b0;
    endtask

    // Fetch one address and compare every output field with the model.
    task automatic fetch_check(input string tag, input logic [31:0] addr);
        int unsigned w;
        int unsigned op;
        int          imm;
        direinstru = addr;
        tick();
        w   = (addr < DEPTH) ? model_mem[addr] : 0;
        op  = w / (1 << 26);
        imm = int'(w % 65536);
        if (imm >= 32768) imm = imm - 65536;
        check({tag, ".instr"}, instruccion, w);
        check({tag, ".err"}, {31'd0, addr_err}, (addr >= DEPTH) ? 1 : 0);
        check({tag, ".valid"}, {31'd0, fetch_valid}, 1);
        check({tag, ".jump"}, {4'd0, instru}, w % (1 << 26));
        check({tag, ".imm"}, extSigno, imm);
        check({tag, ".beq"}, {31'd0, SaltoCond}, (op == 4) ? 1 : 0);
        check({tag, ".j"}, {31'd0, Saltoincond}, (op == 2) ? 1 : 0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, ".instr"}, instruccion, 0);
        check({tag, ".valid"}, {31'd0, fetch_valid}, 0);
        check({tag, ".err"}, {31'd0, addr_err}, 0);
        check({tag, ".ready"}, {31'd0, lif.load_ready}, 1);
        check({tag, ".derived"}, {instru[27:0], SaltoCond, Saltoincond, 2'b00}, 0);
        check({tag, ".imm"}, extSigno, 0);
    endtask

    initial begin
        logic [31:0] boot [4];
        logic [31:0] a;
        boot[0] = 32'h2001_0005;
        boot[1] = 32'h1022_0003;
        boot[2] = 32'h0800_0010;
        boot[3] = 32'h0000_0000;

        reset          = 1'b1;
        direinstru     = '0;
        lif.load_valid = 1'b0;
        lif.load_data  = '0;
        lif.load_last  = 1'b0;
        model_ptr      = 0;
        foreach (model_mem[i]) model_mem[i] = 0;
        #12;
        check_cleared("reset");
        reset = 1'b0;
        #10;

        // Boot load of four words; direinstru is ignored while loading.
        direinstru = 32'd3;
        for (int i = 0; i < 4; i++) load_word(boot[i], i == 3);
        check("t1.ready_off", {31'd0, lif.load_ready}, 0);
        check("t1.no_fetch", instruccion, 0);
        check("t1.no_valid", {31'd0, fetch_valid}, 0);
        for (int i = 0; i < 4; i++) fetch_check("t1.fetch", i);

        // Out of range fetch returns NOP, then recovers.
        fetch_check("t3.oob", 32'd256);
        fetch_check("t3.back", 32'd1);
        fetch_check("t3.oob_hi", 32'h8000_0000);

        // The load port is ignored in RUN.
        lif.load_valid = 1'b1;
        lif.load_data  = 32'hDEAD_BEEF;
        lif.load_last  = 1'b1;
        for (int i = 0; i < 3; i++) fetch_check("t6.ignore", 0);
        check("t6.ready", {31'd0, lif.load_ready}, 0);
        lif.load_valid = 1'b0;
        lif.load_last  = 1'b0;

        // Asynchronous reset between edges clears outputs immediately.
        #2;
        reset = 1'b1;
        #1;
        check_cleared("t5.async");
        #3;
        reset     = 1'b0;
        model_ptr = 0;
        #6;
        load_word(32'h1022_FFFD, 1'b0);
        load_word(32'h0800_0010, 1'b1);
        fetch_check("t5.mem0", 0);
        fetch_check("t5.mem1", 1);
        fetch_check("t5.mem2_kept", 2);
        fetch_check("t2.beq", 0);
        fetch_check("t2.j", 1);
        check("t2.beq_flag", {31'd0, SaltoCond}, 0);

        // Full load with a 3-cycle stall and no load_last.
        #2;
        reset = 1'b1;
        #2;
        reset     = 1'b0;
        model_ptr = 0;
        #6;
        for (int i = 0; i < 3; i++) load_word($urandom, 1'b0);
        for (int i = 0; i < 3; i++) begin
            direinstru = $urandom_range(0, 255);
            tick();
            check("t4.stall_ready", {31'd0, lif.load_ready}, 1);
            check("t4.stall_instr", instruccion, 0);
        end
        for (int i = 3; i < DEPTH; i++) begin
            check("t4.still_loading", {31'd0, lif.load_ready}, 1);
            load_word($urandom, 1'b0);
        end
        check("t4.full_run", {31'd0, lif.load_ready}, 0);
        fetch_check("t4.mem255", 255);
        fetch_check("t4.mem3", 3);
        fetch_check("t4.mem2", 2);

        // Randomized fetch traffic with random load-port noise.
        for (int i = 0; i < 300; i++) begin
            lif.load_valid = 1'($urandom);
            lif.load_last  = 1'($urandom);
            lif.load_data  = $urandom;
            a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1));
            fetch_check("rand", a);
        end
        lif.load_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_instr_fetch_mem
